// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, requester indices and the result-entry struct for the CDB arbiter.
// Optional feature macro used by the top: CDB_BYPASS_EN.
package cdb_arbiter_pkg;

    localparam int NICK_W = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam int CDB_ALU = 0;
    localparam int CDB_BR  = 1;
    localparam int CDB_SLB = 2;

    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
        logic              ac;
        logic [ADDR_W-1:0] j_pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO. Caller only asserts push when ready and pop when non-empty.
module cdb_req_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  cdb_entry_t din,
    output cdb_entry_t dout,
    output logic       ready,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    cdb_entry_t      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    // ready comes from the registered count, so a full FIFO rejects even while popping
    assign ready = (count != (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB among NREQ producer FIFOs.
// `define CDB_BYPASS_EN lets a push into an idle arbiter go straight to the CDB regs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NREQ  = 3,
    parameter  int DEPTH = 2,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          iROB_clr,
    input  logic [NREQ-1:0]               iREQ_en,
    output logic [NREQ-1:0]               oREQ_ready,
    input  logic [NREQ-1:0][NICK_W-1:0]   iREQ_nick,
    input  logic [NREQ-1:0][DATA_W-1:0]   iREQ_dt,
    input  logic [NREQ-1:0]               iREQ_ac,
    input  logic [NREQ-1:0][ADDR_W-1:0]   iREQ_j_pc,
    output logic                          oCDB_en,
    output logic [NICK_W-1:0]             oCDB_nick,
    output logic [DATA_W-1:0]             oCDB_dt,
    output logic                          oCDB_ac,
    output logic [ADDR_W-1:0]             oCDB_j_pc,
    output logic [SRC_W-1:0]              oCDB_src
);

    // returns {found, index} of the first set bit scanning ptr, ptr+1, ... mod NREQ
    function automatic logic [SRC_W:0] rr_pick(input logic [SRC_W-1:0] ptr,
                                               input logic [NREQ-1:0]  vec);
        logic [SRC_W:0] r;
        int             j;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (vec[j]) r = {1'b1, SRC_W'(j)};
        end
        return r;
    endfunction

    cdb_entry_t        req  [NREQ];
    cdb_entry_t        head [NREQ];
    logic [NREQ-1:0]   empty;
    logic [NREQ-1:0]   push_ok;
    logic [NREQ-1:0]   push;
    logic [NREQ-1:0]   pop;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W:0]    q_pick;
    logic              gnt_vld;
    logic [SRC_W-1:0]  gnt_idx;
    cdb_entry_t        gnt_ent;

    assign q_pick = rr_pick(rr_ptr, ~empty);

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign req[g] = '{nick: iREQ_nick[g], dt: iREQ_dt[g], ac: iREQ_ac[g], j_pc: iREQ_j_pc[g]};
        // nick 0 is reserved, so such pushes are silently dropped
        assign push_ok[g] = iREQ_en[g] && oREQ_ready[g] && rdy && !iROB_clr && (iREQ_nick[g] != '0);

        cdb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .en    (rdy),
            .push  (push[g]),
            .pop   (pop[g]),
            .flush (iROB_clr),
            .din   (req[g]),
            .dout  (head[g]),
            .ready (oREQ_ready[g]),
            .empty (empty[g])
        );
    end

`ifdef CDB_BYPASS_EN
    logic [SRC_W:0] b_pick;
    logic           byp;

    assign b_pick = rr_pick(rr_ptr, push_ok);
    assign byp    = (&empty) && b_pick[SRC_W];

    always_comb begin
        push = push_ok;
        if (byp) push[b_pick[SRC_W-1:0]] = 1'b0;
    end

    assign gnt_vld = q_pick[SRC_W] || byp;
    assign gnt_idx = q_pick[SRC_W] ? q_pick[SRC_W-1:0] : b_pick[SRC_W-1:0];
    assign gnt_ent = q_pick[SRC_W] ? head[q_pick[SRC_W-1:0]] : req[b_pick[SRC_W-1:0]];
`else
    assign push    = push_ok;
    assign gnt_vld = q_pick[SRC_W];
    assign gnt_idx = q_pick[SRC_W-1:0];
    assign gnt_ent = head[q_pick[SRC_W-1:0]];
`endif

    always_comb begin
        pop = '0;
        if (rdy && !iROB_clr && q_pick[SRC_W]) pop[q_pick[SRC_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oCDB_en   <= 1'b0;
            oCDB_nick <= '0;
            oCDB_dt   <= '0;
            oCDB_ac   <= 1'b0;
            oCDB_j_pc <= '0;
            oCDB_src  <= '0;
            rr_ptr    <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                oCDB_en <= 1'b0;
                rr_ptr  <= '0;
            end else if (gnt_vld) begin
                oCDB_en   <= 1'b1;
                oCDB_nick <= gnt_ent.nick;
                oCDB_dt   <= gnt_ent.dt;
                oCDB_ac   <= gnt_ent.ac;
                oCDB_j_pc <= gnt_ent.j_pc;
                oCDB_src  <= gnt_idx;
                rr_ptr    <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end else begin
                oCDB_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed test of cdb_arbiter: latency, round-robin order, backpressure, flush, rdy stall, reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic                         clk;
    logic                         rst;
    logic                         rdy;
    logic                         iROB_clr;
    logic [NREQ-1:0]              iREQ_en;
    logic [NREQ-1:0]              oREQ_ready;
    logic [NREQ-1:0][NICK_W-1:0]  iREQ_nick;
    logic [NREQ-1:0][DATA_W-1:0]  iREQ_dt;
    logic [NREQ-1:0]              iREQ_ac;
    logic [NREQ-1:0][ADDR_W-1:0]  iREQ_j_pc;
    logic                         oCDB_en;
    logic [NICK_W-1:0]            oCDB_nick;
    logic [DATA_W-1:0]            oCDB_dt;
    logic                         oCDB_ac;
    logic [ADDR_W-1:0]            oCDB_j_pc;
    logic [1:0]                   oCDB_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.NREQ(NREQ), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .iROB_clr   (iROB_clr),
        .iREQ_en    (iREQ_en),
        .oREQ_ready (oREQ_ready),
        .iREQ_nick  (iREQ_nick),
        .iREQ_dt    (iREQ_dt),
        .iREQ_ac    (iREQ_ac),
        .iREQ_j_pc  (iREQ_j_pc),
        .oCDB_en    (oCDB_en),
        .oCDB_nick  (oCDB_nick),
        .oCDB_dt    (oCDB_dt),
        .oCDB_ac    (oCDB_ac),
        .oCDB_j_pc  (oCDB_j_pc),
        .oCDB_src   (oCDB_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] dt_of(input int n);
        return 32'hA000_0000 | DATA_W'(n);
    endfunction

    function automatic logic [ADDR_W-1:0] pc_of(input int n);
        return 32'h0000_1000 + ADDR_W'(n * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int n);
        iREQ_en[i]   = 1'b1;
        iREQ_nick[i] = NICK_W'(n);
        iREQ_dt[i]   = dt_of(n);
        iREQ_ac[i]   = n[0];
        iREQ_j_pc[i] = pc_of(n);
    endtask

    task automatic exp_bc(input string tag, input int n, input int src);
        chk({tag, ".en"},   64'(oCDB_en),   64'd1);
        chk({tag, ".nick"}, 64'(oCDB_nick), 64'(n));
        chk({tag, ".src"},  64'(oCDB_src),  64'(src));
        chk({tag, ".dt"},   64'(oCDB_dt),   64'(dt_of(n)));
        chk({tag, ".pc"},   64'(oCDB_j_pc), 64'(pc_of(n)));
    endtask

    task automatic do_flush();
        iROB_clr = 1'b1;
        tick();
        iROB_clr = 1'b0;
    endtask

    initial begin
        int exp_n [6];
        int exp_s [6];

        rst = 1'b1; rdy = 1'b1; iROB_clr = 1'b0;
        iREQ_en = '0; iREQ_nick = '0; iREQ_dt = '0; iREQ_ac = '0; iREQ_j_pc = '0;
        #2;
        chk("rst.en",   64'(oCDB_en),   64'd0);
        chk("rst.nick", 64'(oCDB_nick), 64'd0);
        chk("rst.src",  64'(oCDB_src),  64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst.ready", 64'(oREQ_ready), 64'b111);

`ifdef CDB_BYPASS_EN
        set_req(1, 7);
        tick();
        iREQ_en = '0;
        exp_bc("byp1", 7, 1);
        tick();
        chk("byp1.idle", 64'(oCDB_en), 64'd0);

        // rr_ptr=2 now: req2 bypasses, req0 enqueues
        set_req(0, 4);
        set_req(2, 5);
        tick();
        iREQ_en = '0;
        exp_bc("byp2.a", 5, 2);
        tick();
        exp_bc("byp2.b", 4, 0);
        tick();
        chk("byp2.idle", 64'(oCDB_en), 64'd0);
`else
        // single push: visible two edges later
        iREQ_en = 3'b001; iREQ_nick[0] = 5'd3; iREQ_dt[0] = 32'h55;
        iREQ_ac[0] = 1'b1; iREQ_j_pc[0] = pc_of(3);
        tick();
        iREQ_en = '0;
        chk("single.early", 64'(oCDB_en), 64'd0);
        tick();
        chk("single.en",   64'(oCDB_en),   64'd1);
        chk("single.nick", 64'(oCDB_nick), 64'd3);
        chk("single.dt",   64'(oCDB_dt),   64'h55);
        chk("single.src",  64'(oCDB_src),  64'd0);
        chk("single.ac",   64'(oCDB_ac),   64'd1);
        tick();
        chk("single.off", 64'(oCDB_en), 64'd0);

        // round robin with all three loaded two deep
        do_flush();
        for (int i = 0; i < 3; i++) set_req(i, 8 + 2*i);
        tick();
        for (int i = 0; i < 3; i++) set_req(i, 9 + 2*i);
        tick();
        iREQ_en = '0;
        exp_n = '{8, 10, 12, 9, 11, 13};
        exp_s = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < 6; k++) begin
            exp_bc($sformatf("rr%0d", k), exp_n[k], exp_s[k]);
            tick();
        end
        chk("rr.off", 64'(oCDB_en), 64'd0);

        // backpressure on req2
        do_flush();
        set_req(0, 1); set_req(2, 20);
        tick();
        set_req(0, 2); set_req(2, 21);
        tick();
        exp_bc("bp.a", 1, 0);
        chk("bp.ready_full", 64'(oREQ_ready), 64'b011);
        iREQ_en[0] = 1'b0;
        set_req(2, 22);
        tick();
        exp_bc("bp.b", 20, 2);
        chk("bp.ready_back", 64'(oREQ_ready), 64'b111);
        tick();
        iREQ_en = '0;
        exp_bc("bp.c", 2, 0);
        tick();
        exp_bc("bp.d", 21, 2);
        tick();
        exp_bc("bp.e", 22, 2);
        tick();
        chk("bp.off", 64'(oCDB_en), 64'd0);

        // flush with entries queued and req1 pushing
        do_flush();
        for (int i = 0; i < 3; i++) set_req(i, 1 + i);
        tick();
        for (int i = 0; i < 3; i++) set_req(i, 4 + i);
        tick();
        exp_bc("fl.pre", 1, 0);
        iREQ_en = '0;
        set_req(1, 7);
        iROB_clr = 1'b1;
        tick();
        iROB_clr = 1'b0;
        iREQ_en = '0;
        chk("fl.en",    64'(oCDB_en),    64'd0);
        chk("fl.ready", 64'(oREQ_ready), 64'b111);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl.quiet%0d", k), 64'(oCDB_en), 64'd0);
        end

        // rdy stall mid-stream
        for (int i = 0; i < 3; i++) set_req(i, 1 + i);
        tick();
        iREQ_en = '0;
        tick();
        exp_bc("stall.a", 1, 0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_bc($sformatf("stall.hold%0d", k), 1, 0);
        end
        rdy = 1'b1;
        tick();
        exp_bc("stall.b", 2, 1);
        tick();
        exp_bc("stall.c", 3, 2);
        tick();
        chk("stall.off", 64'(oCDB_en), 64'd0);

        // nick 0 is never accepted
        set_req(0, 0);
        tick();
        iREQ_en = '0;
        tick();
        chk("nick0.off", 64'(oCDB_en), 64'd0);
`endif

        // async reset mid-stream
        for (int i = 0; i < 3; i++) set_req(i, 17 + i);
        tick();
        iREQ_en = '0;
        tick();
        chk("arst.pre", 64'(oCDB_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.en",    64'(oCDB_en),    64'd0);
        chk("arst.nick",  64'(oCDB_nick),  64'd0);
        chk("arst.ready", 64'(oREQ_ready), 64'b111);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("arst.quiet", 64'(oCDB_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
